// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wport_arbiter
//  Purpose  : Shares the single register-file write port among NREQ writeback
//             sources (ALU result, load data, CP0/HI-LO move, ...). Grants at
//             most one valid/ready transfer per cycle and registers the write
//             command towards the regfile. Writes to r0 are filtered. A stall
//             flag is raised for the pipeline. Waiting requesters are aged so
//             that none of them starves.
//  Ports    : clk        - clock, state updates on posedge
//             rst        - asynchronous active-high reset
//             req_valid  - [NREQ] requester i holds a write
//             req_addr   - [NREQ*AW] destination register, slice i*AW +: AW
//             req_data   - [NREQ*DW] write data, slice i*DW +: DW
//             req_ready  - [NREQ] one-hot (or zero) grant
//             rf_we      - registered regfile write enable
//             rf_waddr   - registered regfile write address
//             rf_wdata   - registered regfile write data
//             stall      - a valid requester is not granted this cycle
//             starve     - a forced-priority (starvation) grant is active
//  Config   : RF_ARB_RR_EN defined   -> round-robin normal priority
//             RF_ARB_RR_EN undefined -> fixed priority, lowest index wins
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter #(
    parameter int NREQ       = 3,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic               stall,
    output logic               starve
);

    // Wait counters only ever need to reach STARVE_MAX (at most 15).
    localparam int              c_CW         = 4;
    localparam logic [c_CW-1:0] c_STARVE_CNT = c_CW'(STARVE_MAX);

    logic [c_CW-1:0] wait_cnt_q [NREQ];
    logic [c_CW-1:0] wait_cnt_d [NREQ];
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

    logic [NREQ-1:0] w_starve_hit;
    logic [NREQ-1:0] w_starve_gnt;
    logic            w_starve_any;
    logic [NREQ-1:0] w_norm_gnt;
    logic            w_norm_found;
    logic [NREQ-1:0] w_gnt;
    logic            w_gnt_any;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    // ------------------------------------------------------------------
    // Starvation override: lowest index whose counter has saturated.
    // Qualified with valid so a withdrawn requester is never granted in
    // the cycle its counter still shows the saturated value.
    // ------------------------------------------------------------------
    always_comb begin
        w_starve_hit = '0;
        w_starve_gnt = '0;
        w_starve_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_starve_hit[i] = req_valid[i] && (wait_cnt_q[i] == c_STARVE_CNT);
            if (w_starve_hit[i] && !w_starve_any) begin
                w_starve_gnt[i] = 1'b1;
                w_starve_any    = 1'b1;
            end
        end
    end

`ifdef RF_ARB_RR_EN
    // ------------------------------------------------------------------
    // Round-robin normal priority: search starts just after the last
    // granted index. The pointer follows every grant, starve grants too.
    // ------------------------------------------------------------------
    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [c_IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [c_IW-1:0] w_gnt_idx;
    int              w_rr_idx;

    always_comb begin
        w_norm_gnt   = '0;
        w_norm_found = 1'b0;
        w_rr_idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_rr_idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!w_norm_found && req_valid[w_rr_idx]) begin
                w_norm_gnt[w_rr_idx] = 1'b1;
                w_norm_found         = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx = c_IW'(i);
            end
        end
        rr_ptr_d = w_gnt_any ? w_gnt_idx : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= c_IW'(NREQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // ------------------------------------------------------------------
    // Fixed normal priority: lowest valid index wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_norm_gnt   = '0;
        w_norm_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_norm_found && req_valid[i]) begin
                w_norm_gnt[i] = 1'b1;
                w_norm_found  = 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Final grant. Held at zero while reset is asserted so no transfer can
    // be observed by a requester during reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        if (!rst) begin
            w_gnt = w_starve_any ? w_starve_gnt : w_norm_gnt;
        end
        w_gnt_any = |w_gnt;
    end

    // One-hot select of the granted requester's address and data.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: wait counters age while valid and not granted, and clear
    // on grant or withdrawal. The write command is rebuilt every cycle; a
    // transfer to r0 still consumes the grant but does not enable a write.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!req_valid[i] || w_gnt[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != c_STARVE_CNT) begin
                wait_cnt_d[i] = wait_cnt_q[i] + c_CW'(1);
            end
        end
        rf_we_d    = w_gnt_any && (w_sel_addr != '0);
        rf_waddr_d = w_gnt_any ? w_sel_addr : rf_waddr_q;
        rf_wdata_d = w_gnt_any ? w_sel_data : rf_wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign req_ready = w_gnt;
    assign stall     = !rst && (|(req_valid & ~w_gnt));
    assign starve    = !rst && w_starve_any;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

endmodule
`default_nettype wire
